// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow, synchronous flush and an optional
// first-word-fall-through read port. Pointers wrap at any depth.
module sync_fifo_ctrl #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_MEM_DEPTH  = 333,
  parameter int unsigned P_AF_LEVEL   = 330,
  parameter int unsigned P_AE_LEVEL   = 3,
  parameter int unsigned P_FWFT       = 0
) (
  input  logic                                 CLK,
  input  logic                                 RST_n,
  input  logic [P_DATA_WIDTH-1:0]              DATA_IN,
  input  logic                                 W_EN,
  input  logic                                 R_EN,
  input  logic                                 FLUSH,
  input  logic                                 CLR_ERR,
  output logic [P_DATA_WIDTH-1:0]              DATA_OUT,
  output logic [$clog2(P_MEM_DEPTH+1)-1:0]     COUNT,
  output logic                                 FULL,
  output logic                                 EMPTY,
  output logic                                 ALMOST_FULL,
  output logic                                 ALMOST_EMPTY,
  output logic                                 OVERFLOW,
  output logic                                 UNDERFLOW
);

  localparam int unsigned CW = $clog2(P_MEM_DEPTH + 1);
  localparam int unsigned AW = (P_MEM_DEPTH > 1) ? $clog2(P_MEM_DEPTH) : 1;

  logic [P_DATA_WIDTH-1:0] mem [P_MEM_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          full, empty;
  logic          wr_acc, rd_acc;

  // Status decode from registered occupancy
  always_comb begin
    full  = (count_q == CW'(P_MEM_DEPTH));
    empty = (count_q == '0);
  end

  // Accept decisions; flush suppresses both transfers
  always_comb begin
    rd_acc = R_EN & ~empty & ~FLUSH;
    wr_acc = W_EN & (~full | (R_EN & ~empty)) & ~FLUSH;
  end

  // Next-state for pointers, count and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == AW'(P_MEM_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = (rd_ptr_q == AW'(P_MEM_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CW'(1);
      end
    end
    // Clear first so a same-cycle set takes precedence
    if (CLR_ERR) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (!FLUSH && W_EN && !wr_acc) ovf_d = 1'b1;
    if (!FLUSH && R_EN && !rd_acc) unf_d = 1'b1;
  end

  // Control state registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr_q] <= DATA_IN;
  end

  generate
    if (P_FWFT != 0) begin : g_fwft
      // Head word presented directly while data is present
      always_comb begin
        DATA_OUT = empty ? '0 : mem[rd_ptr_q];
      end
    end else begin : g_reg
      logic [P_DATA_WIDTH-1:0] dout_q, dout_d;

      // Output word loads only on an accepted read
      always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem[rd_ptr_q];
      end

      // Registered read data
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      always_comb begin
        DATA_OUT = dout_q;
      end
    end
  endgenerate

  // Output drive
  always_comb begin
    COUNT        = count_q;
    FULL         = full;
    EMPTY        = empty;
    ALMOST_FULL  = (count_q >= CW'(P_AF_LEVEL));
    ALMOST_EMPTY = (count_q <= CW'(P_AE_LEVEL));
    OVERFLOW     = ovf_q;
    UNDERFLOW    = unf_q;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: registered-read and FWFT instances share one
// stimulus stream and are checked against a queue-based reference.
module tb_sync_fifo_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned AF    = 4;
  localparam int unsigned AE    = 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          w_en, r_en, flush, clr_err;

  logic [DW-1:0] dout0, dout1;
  logic [CW-1:0] count0, count1;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic          full1, empty1, af1, ae1, ovf1, unf1;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  int   q[$];
  bit   m_ovf, m_unf;
  int   m_dout;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.P_DATA_WIDTH(DW), .P_MEM_DEPTH(DEPTH), .P_AF_LEVEL(AF),
                   .P_AE_LEVEL(AE), .P_FWFT(0)) u_reg (
    .CLK(clk), .RST_n(rst_n), .DATA_IN(din), .W_EN(w_en), .R_EN(r_en),
    .FLUSH(flush), .CLR_ERR(clr_err), .DATA_OUT(dout0), .COUNT(count0),
    .FULL(full0), .EMPTY(empty0), .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0),
    .OVERFLOW(ovf0), .UNDERFLOW(unf0));

  sync_fifo_ctrl #(.P_DATA_WIDTH(DW), .P_MEM_DEPTH(DEPTH), .P_AF_LEVEL(AF),
                   .P_AE_LEVEL(AE), .P_FWFT(1)) u_fwft (
    .CLK(clk), .RST_n(rst_n), .DATA_IN(din), .W_EN(w_en), .R_EN(r_en),
    .FLUSH(flush), .CLR_ERR(clr_err), .DATA_OUT(dout1), .COUNT(count1),
    .FULL(full1), .EMPTY(empty1), .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1),
    .OVERFLOW(ovf1), .UNDERFLOW(unf1));

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    int fw;
    n  = q.size();
    fw = (n == 0) ? 0 : q[0];
    check({ctx, ":count"},    int'(count0), n);
    check({ctx, ":full"},     int'(full0),  int'(n == DEPTH));
    check({ctx, ":empty"},    int'(empty0), int'(n == 0));
    check({ctx, ":afull"},    int'(af0),    int'(n >= AF));
    check({ctx, ":aempty"},   int'(ae0),    int'(n <= AE));
    check({ctx, ":ovf"},      int'(ovf0),   int'(m_ovf));
    check({ctx, ":unf"},      int'(unf0),   int'(m_unf));
    check({ctx, ":dout"},     int'(dout0),  m_dout);
    check({ctx, ":f_count"},  int'(count1), n);
    check({ctx, ":f_empty"},  int'(empty1), int'(n == 0));
    check({ctx, ":f_full"},   int'(full1),  int'(n == DEPTH));
    check({ctx, ":f_ovf"},    int'(ovf1),   int'(m_ovf));
    check({ctx, ":f_unf"},    int'(unf1),   int'(m_unf));
    check({ctx, ":f_dout"},   int'(dout1),  fw);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = 0;
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check.
  task automatic cyc(input string ctx, input bit w, input bit r, input bit f,
                     input bit c, input int d);
    bit was_full, was_empty, rd, wr;
    w_en = w; r_en = r; flush = f; clr_err = c; din = DW'(d);
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (f) begin
      q.delete();
    end else begin
      rd = r && !was_empty;
      wr = w && (!was_full || rd);
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(d & 8'hFF);
      if (w && !wr) m_ovf = 1'b1;
      if (r && !rd) m_unf = 1'b1;
    end
    #1;
    check_all(ctx);
  endtask

  initial begin
    bit w, r, f, c;
    int pw;
    rst_n = 1'b0; w_en = 0; r_en = 0; flush = 0; clr_err = 0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // fill then drain, in-order data
    for (int i = 1; i <= 5; i++) cyc("fill", 1, 0, 0, 0, i * 8'h11);
    for (int i = 0; i < 5; i++)  cyc("drain", 0, 1, 0, 0, 0);

    // overflow while full, then clear
    for (int i = 1; i <= 5; i++) cyc("refill", 1, 0, 0, 0, 8'h20 + i);
    cyc("ovf", 1, 0, 0, 0, 8'h66);
    cyc("clr", 0, 0, 0, 1, 0);

    // simultaneous read/write while full, pointers wrap
    for (int i = 0; i < 3; i++) cyc("rw_full", 1, 1, 0, 0, 8'h70 + i);
    for (int i = 0; i < 5; i++) cyc("drain2", 0, 1, 0, 0, 0);

    // underflow on empty, then write+read on empty
    cyc("unf", 0, 1, 0, 0, 0);
    cyc("wr_rd_empty", 1, 1, 0, 0, 8'hA5);
    cyc("clr_set", 0, 1, 0, 1, 0);
    cyc("clr2", 0, 0, 0, 1, 0);

    // flush with concurrent write
    cyc("to3a", 1, 0, 0, 0, 8'h01);
    cyc("to3b", 1, 0, 0, 0, 8'h02);
    cyc("flush", 1, 0, 1, 0, 8'hEE);
    cyc("fwft_wr", 1, 0, 0, 0, 8'h3C);
    cyc("fwft_hold", 0, 0, 0, 0, 0);
    cyc("fwft_rd", 0, 1, 0, 0, 0);

    // async reset mid-burst, observed before the next edge
    cyc("burst1", 1, 0, 0, 0, 8'h91);
    cyc("burst2", 1, 0, 0, 0, 8'h92);
    cyc("burst3", 1, 1, 0, 0, 8'h93);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    w_en = 0; r_en = 0;

    // randomized traffic with alternating write/read bias
    pw = 3;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) pw = (pw == 3) ? 1 : 3;
      w = ($urandom_range(3) < pw);
      r = ($urandom_range(3) < 4 - pw);
      f = ($urandom_range(49) == 0);
      c = ($urandom_range(19) == 0);
      cyc("rand", w, r, f, c, int'($urandom_range(255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
